// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
// Double-buffered 8x8 red/green LED matrix row scanner. A producer fills the
// back buffer row by row and requests a swap; the scanner swaps front and back
// only at the frame boundary so a displayed frame never mixes two buffers.
// Each row is shown as BLANK_CYCLES of columns-off followed by SCAN_DIV cycles
// of column data, so the row select never moves while any column is lit.
//
// Handshake: swap_req is a single-cycle request that is remembered in a
// pending flag (repeats coalesce). swap_ack pulses for exactly one cycle, the
// cycle whose closing edge exchanges the buffers; a write in that cycle still
// lands in the pre-swap back buffer and therefore shows in the new front.
//
// led bus map (index 0 on the left):
//   led[0:7]   red columns,   pixel y=k on led[7-k],  active-low
//   led[8:15]  green columns, pixel y=k on led[15-k], active-low
//   led[16:23] unused, held high
//   led[24:26] row index, led[24] is the MSB
//   led[27]    high whenever out of reset

module led_matrix_scanner #(
  parameter int unsigned SCAN_DIV     = 25000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        wr_en,
  input  logic [2:0]  wr_row,
  input  logic [7:0]  wr_red,
  input  logic [7:0]  wr_green,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic [0:27] led
);

  // Last counter value of each phase; the counter restarts at 0 on entry.
  localparam logic [24:0] DRIVE_LAST = 25'(SCAN_DIV - 1);
  localparam logic [24:0] BLANK_LAST = 25'(BLANK_CYCLES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Scan state (readable by name for checkers bound to this module)
  state_t      state_q;
  state_t      state_d;
  logic [24:0] cnt_q;
  logic [24:0] cnt_d;
  logic [2:0]  row_q;
  logic [2:0]  row_d;

  // Buffer control
  logic        front_q;    // index of the displayed buffer
  logic        pending_q;  // a swap has been requested and not yet done
  logic        frame_end;  // last DRIVE cycle of row 7
  logic        swap_fire;  // the buffers exchange on the closing edge

  // Two frame buffers, each row packed as {red[7:0], green[7:0]}
  logic [15:0] fb_q [2][8];
  logic [15:0] row_pix;

  // Next value of the registered led bus
  logic [0:27] led_d;

  assign frame_end = (state_q == ST_DRIVE) && (cnt_q == DRIVE_LAST) && (row_q == 3'd7);
  assign swap_fire = frame_end && pending_q;

  // Gated by RST_N so no acknowledge escapes in the first reset cycle.
  assign swap_ack  = RST_N & swap_fire;

  // Front row pixels for the row about to be driven; the row only changes on
  // DRIVE->BLANK edges, so row_q is already the row of the next DRIVE phase.
  assign row_pix   = fb_q[front_q][row_q];

  // Back-buffer writes; the write address uses the pre-swap front index, so a
  // write in the swap cycle ends up in the new front buffer.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          fb_q[b][r] <= '0;
        end
      end
    end else if (wr_en) begin
      fb_q[~front_q][wr_row] <= {wr_red, wr_green};
    end
  end

  // Swap request bookkeeping: a request in the swap cycle re-arms the flag.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      front_q   <= 1'b0;
      pending_q <= 1'b0;
    end else if (swap_fire) begin
      front_q   <= ~front_q;
      pending_q <= swap_req;
    end else if (swap_req) begin
      pending_q <= 1'b1;
    end
  end

  // FSM state register: phase, phase counter and current row.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  // FSM next state: count through BLANK then DRIVE, advancing the row after DRIVE.
  always_comb begin
    state_d = state_q;
    cnt_d   = 25'(cnt_q + 25'd1);
    row_d   = row_q;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          row_d   = 3'(row_q + 3'd1);
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs: led bus for the state being entered, so columns and row
  // select change together on the transition edge.
  always_comb begin
    led_d        = '1;
    led_d[24:26] = row_d;
    led_d[27]    = 1'b1;
    if (state_d == ST_DRIVE) begin
      led_d[0:7]  = ~row_pix[15:8];
      led_d[8:15] = ~row_pix[7:0];
    end
  end

  // Registered led bus; reset drives columns off, row 0 and led[27] low.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      led <= 28'hFFF_FFF0;
    end else begin
      led <= led_d;
    end
  end

endmodule
